bnn_xnor_neuron: RTL and testbench
==================================

# bnn_xnor_neuron

Binary-neuron stage that sits directly downstream of the 8-bit counter/loader and consumes its 8-bit output words. It accepts a group of `WORDS` 8-bit input words, XNORs each word against a stored 8-bit weight word, and accumulates the popcount. When the group is complete, it compares the sum against a programmable threshold and emits one binary activation bit plus the raw sum over a valid/ready handshake.

## Interface

Parameters:

- `WORDS`, default 4: input words per activation; legal range 2–16.
- `ACC_W`, derived localparam `$clog2(8*WORDS+1)`: accumulator and sum width; 6 bits when `WORDS`=4.

Ports:

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ena`  in  1  global enable; when low, no handshake or load takes effect and all state holds.
- `wt_load`  in  1  write `wt_data` into weight[wt_ptr].
- `wt_data`  in  8  weight word.
- `thr_load`  in  1  write `thr_data` into the threshold register.
- `thr_data`  in  ACC_W  threshold value.
- `in_valid`  in  1  input word is valid.
- `in_data`  in  8  input activation word.
- `in_ready`  out  1  block can accept an input word.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_bit`  out  1  activation: 1 when sum ≥ threshold.
- `out_sum`  out  ACC_W  XNOR-popcount sum of the group.

## Operation

- The FSM has two states, ACCUM and DONE. Reset state is ACCUM.
- **ACCUM:**
  - `in_ready` = `ena`.
  - An input word is accepted when `in_valid & in_ready`.
  - On acceptance: acc += popcount(~(in_data ^ weight[idx])), then idx++.
  - Accepting the word at idx = WORDS-1 does the following:
    - `out_sum` ← acc + pc.
    - `out_bit` ← (acc + pc ≥ thr).
    - acc ← 0, idx ← 0.
    - The FSM moves to DONE.
- **DONE:**
  - `out_valid` = 1 and `in_ready` = 0.
  - `in_valid` is ignored.
  - When `out_ready & ena`, `out_valid` drops and the FSM returns to ACCUM.
- **Weight load:** when `wt_load & ena`, weight[wt_ptr] ← `wt_data` and wt_ptr increments. wt_ptr wraps from WORDS-1 to 0. Loads are legal in either state.
- **Threshold load:** when `thr_load & ena`, thr ← `thr_data`. Legal in either state.
- **Weight write and read in the same cycle:** accumulation uses the pre-write weight. The new weight applies from the next cycle.
- **Threshold load in DONE:** the latched `out_bit` is unchanged. The new threshold applies to the next group.
- **Arithmetic:** popcount is 0–8. The accumulator cannot overflow by construction of `ACC_W`. The comparison is unsigned.

## Timing

- **Reset values:**
  - `out_valid`=0, `out_bit`=0, `out_sum`=0.
  - `in_ready`=`ena`.
  - acc=0, idx=0, wt_ptr=0.
  - All weights = 8'h00.
  - thr = 4*WORDS (16 when `WORDS`=4).
- **Latency:** `out_valid` rises on the clock edge that accepts the last word of a group, so it is visible in the following cycle.
- **Throughput:** the DONE→ACCUM transition costs one cycle with `in_ready`=0. The minimum is WORDS+1 cycles per activation.
- **Output stability:** `out_valid`, `out_bit` and `out_sum` are registered and held stable while `out_valid` is high and `out_ready` is low.
- **`ena` low:**
  - `in_ready`=0.
  - FSM, acc, idx, weights and thr all hold.
  - `out_valid` holds its value.
- **Reset mid-group:** any partial accumulation is discarded. The next accepted word is treated as idx 0.

## Structure

- **Shared package `bnn_pkg`:**
  - `WORD_W`=8.
  - FSM state typedef {ACCUM, DONE}.
  - A function for the reset threshold: 4*WORDS.
- **Sub-module `popcount8`:** purely combinational. Takes an 8-bit input and produces a 4-bit count.
- **Top level holds:** the weight register array, pointers, accumulator, comparator and FSM.

## Test plan

All scenarios use `WORDS`=4.

1. **Reset:** assert `reset` mid-run, then release with `ena`=1.
   - Required: `out_valid`=0, `out_sum`=0, `out_bit`=0, `in_ready`=1.
2. **Default weights:** with weights at 00, feed 4×8'h00 back-to-back with `out_ready`=1.
   - Required: `out_valid` one cycle after the 4th accept, `out_sum`=32, `out_bit`=1 (threshold 16).
3. **Loaded weights:**
   - Load weights FF, 0F, F0, AA, then feed 00, 0F, 0F, 55. Required: `out_sum`=8, `out_bit`=0.
   - Then `thr_load` 8 and repeat the same inputs. Required: `out_sum`=8, `out_bit`=1.
4. **Backpressure:** hold `out_ready`=0 for 5 cycles while driving `in_valid`=1.
   - Required while held: `out_valid`, `out_bit` and `out_sum` remain stable, `in_ready`=0, and no words are consumed.
   - Required after `out_ready` pulses: `in_ready` returns after one bubble cycle, and the next group's sum is independent of the previous group.
5. **Mid-group reset:** accept 2 words, assert `reset`, then feed a fresh group of 4×00 with default weights.
   - Required: `out_sum`=32.
6. **Pointer wrap and enable gating:**
   - Issue 5 `wt_load` writes of 01, 02, 03, 04, 80, then feed 4×00. Required: `out_sum`=7+7+6+7=27, showing that weight[0] was overwritten by 80.
   - With `ena`=0, drive `wt_load`, `thr_load` and `in_valid`. Required: no state change.

Source files
------------

// File: rtl/bnn_pkg.sv
`default_nettype none
// bnn_pkg: shared word width, FSM state type and reset-threshold helper for the binary neuron.
package bnn_pkg;

  localparam int WORD_W = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Half of the maximum possible sum: a neutral starting threshold.
  function automatic int reset_thr(input int words);
    return 4 * words;
  endfunction

endpackage
`default_nettype wire

// File: rtl/popcount8.sv
`default_nettype none
// popcount8: combinational count of set bits in an 8-bit word.
module popcount8
  import bnn_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  output logic [3:0]        count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WORD_W; i++) begin
      count = count + 4'(data[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bnn_xnor_neuron.sv
`default_nettype none
// bnn_xnor_neuron: XNOR-popcount accumulation over WORDS input words, thresholded to one
// activation bit and returned with the raw sum over a valid/ready handshake.
module bnn_xnor_neuron
  import bnn_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int ACC_W = $clog2(8 * WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic              wt_load,
  input  logic [WORD_W-1:0] wt_data,
  input  logic              thr_load,
  input  logic [ACC_W-1:0]  thr_data,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [ACC_W-1:0]  out_sum
);

  localparam int              IDX_W    = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [ACC_W-1:0] THR_RST  = ACC_W'(reset_thr(WORDS));

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] weight [WORDS];
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  wt_ptr;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  thr;
  logic [ACC_W-1:0]  sum_nxt;
  logic [WORD_W-1:0] xnor_word;
  logic [3:0]        pc;
  logic              accept;
  logic              last;

  // Weight read is from the register array, so a same-cycle write is seen only next cycle.
  assign xnor_word = ~(in_data ^ weight[idx]);

  popcount8 u_popcount8 (
    .data  (xnor_word),
    .count (pc)
  );

  assign accept  = in_valid & in_ready;
  assign last    = accept & (idx == LAST_IDX);
  assign sum_nxt = acc + ACC_W'(pc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last) state_nxt = DONE;
      DONE:    if (out_ready && ena) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = ena && (state == ACCUM);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      idx     <= '0;
      out_sum <= '0;
      out_bit <= 1'b0;
    end else if (accept) begin
      if (last) begin
        out_sum <= sum_nxt;
        out_bit <= (sum_nxt >= thr);
        acc     <= '0;
        idx     <= '0;
      end else begin
        acc <= sum_nxt;
        idx <= idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        weight[i] <= '0;
      end
      wt_ptr <= '0;
    end else if (wt_load && ena) begin
      weight[wt_ptr] <= wt_data;
      wt_ptr         <= (wt_ptr == LAST_IDX) ? '0 : wt_ptr + 1'b1;
    end
  end

  // out_bit is latched at group completion, so a load during DONE affects only the next group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr <= THR_RST;
    end else if (thr_load && ena) begin
      thr <= thr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bnn_xnor_neuron.sv
`default_nettype none
// tb_bnn_xnor_neuron: directed scenarios plus a randomized run against a group-level reference model.
module tb_bnn_xnor_neuron;

  localparam int WORDS = 4;
  localparam int ACC_W = $clog2(8 * WORDS + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ena = 1'b1;
  logic             wt_load = 1'b0;
  logic [7:0]       wt_data = '0;
  logic             thr_load = 1'b0;
  logic [ACC_W-1:0] thr_data = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_bit;
  logic [ACC_W-1:0] out_sum;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] m_w [WORDS];
  int         m_thr;
  int         m_ptr;

  always #5 clk = ~clk;

  bnn_xnor_neuron #(.WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .ena(ena),
    .wt_load(wt_load), .wt_data(wt_data),
    .thr_load(thr_load), .thr_data(thr_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_sum(out_sum)
  );

  function automatic int grp_sum(input logic [31:0] w);
    int s = 0;
    for (int i = 0; i < WORDS; i++) s += $countones(~(w[8*i +: 8] ^ m_w[i]));
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < WORDS; i++) m_w[i] = 8'h00;
    m_thr = 4 * WORDS;
    m_ptr = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; wt_load = 1'b0; thr_load = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Returns at the negedge following the acceptance of the last word.
  task automatic feed_words(input logic [31:0] w, input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[8*i +: 8];
      while (!in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_wt(input logic [7:0] d);
    @(negedge clk);
    wt_load = 1'b1; wt_data = d;
    @(negedge clk);
    wt_load = 1'b0;
    m_w[m_ptr] = d;
    m_ptr = (m_ptr + 1) % WORDS;
  endtask

  task automatic test_default_weights();
    bit ok;
    out_ready = 1'b1;
    feed_words(32'h0000_0000, 4, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL default_accept: in_ready timeout"); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL default_latency: out_valid=%0b want 1", out_valid); end
    n_checks++; if (out_sum !== 6'd32) begin n_fail++; $display("FAIL default_sum: got %0d want 32", out_sum); end
    n_checks++; if (out_bit !== 1'b1) begin n_fail++; $display("FAIL default_bit: got %0b want 1", out_bit); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL default_bubble: in_ready=%0b want 0", in_ready); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL default_consume: out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    bit ok;
    feed_words(32'h0000_0000, 2, ok);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_sum !== '0 || out_bit !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: valid=%0b sum=%0d bit=%0b want 0/0/0", out_valid, out_sum, out_bit);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || out_sum !== '0 || out_bit !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: valid=%0b sum=%0d bit=%0b rdy=%0b want 0/0/0/1",
                         out_valid, out_sum, out_bit, in_ready);
    end
  endtask

  task automatic test_loaded_weights();
    bit ok;
    load_wt(8'hFF); load_wt(8'h0F); load_wt(8'hF0); load_wt(8'hAA);
    feed_words(32'h550F_0F00, 4, ok);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 6'd8 || out_bit !== 1'b0) begin
      n_fail++; $display("FAIL loaded_thr16: valid=%0b sum=%0d bit=%0b want 1/8/0", out_valid, out_sum, out_bit);
    end
    thr_load = 1'b1; thr_data = 6'd8;
    @(negedge clk);
    thr_load = 1'b0;
    m_thr = 8;
    feed_words(32'h550F_0F00, 4, ok);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 6'd8 || out_bit !== 1'b1) begin
      n_fail++; $display("FAIL loaded_thr8: valid=%0b sum=%0d bit=%0b want 1/8/1", out_valid, out_sum, out_bit);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] g1, g2;
    logic [ACC_W-1:0] s0;
    logic b0;
    int exp;
    g1 = $urandom; g2 = $urandom;
    @(negedge clk);
    out_ready = 1'b0;
    feed_words(g1, 4, ok);
    exp = grp_sum(g1);
    n_checks++; if (out_valid !== 1'b1 || int'(out_sum) != exp || out_bit !== (exp >= m_thr)) begin
      n_fail++; $display("FAIL bp_result: valid=%0b sum=%0d bit=%0b want sum %0d", out_valid, out_sum, out_bit, exp);
    end
    s0 = out_sum; b0 = out_bit;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || out_sum !== s0 || out_bit !== b0 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d valid=%0b sum=%0d bit=%0b rdy=%0b want 1/%0d/%0b/0",
                           c, out_valid, out_sum, out_bit, in_ready, s0, b0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: rdy=%0b valid=%0b want 1/0", in_ready, out_valid);
    end
    feed_words(g2, 4, ok);
    exp = grp_sum(g2);
    n_checks++; if (ok !== 1'b1 || out_valid !== 1'b1 || int'(out_sum) != exp) begin
      n_fail++; $display("FAIL bp_next_group: valid=%0b sum=%0d want 1/%0d", out_valid, out_sum, exp);
    end
  endtask

  task automatic test_mid_group_reset();
    bit ok;
    feed_words(32'h0000_0000, 2, ok);
    do_reset();
    feed_words(32'h0000_0000, 4, ok);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 6'd32) begin
      n_fail++; $display("FAIL mid_reset: valid=%0b sum=%0d want 1/32", out_valid, out_sum);
    end
  endtask

  task automatic test_wrap_and_enable();
    bit ok;
    @(negedge clk);
    load_wt(8'h01); load_wt(8'h02); load_wt(8'h03); load_wt(8'h04); load_wt(8'h80);
    out_ready = 1'b0;
    feed_words(32'h0000_0000, 4, ok);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 6'd27 || out_bit !== 1'b1) begin
      n_fail++; $display("FAIL wrap_sum: valid=%0b sum=%0d bit=%0b want 1/27/1", out_valid, out_sum, out_bit);
    end
    ena = 1'b0; out_ready = 1'b1;
    wt_load = 1'b1; wt_data = 8'hFF; thr_load = 1'b1; thr_data = 6'd31; in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 6'd27) begin
        n_fail++; $display("FAIL ena_hold: valid=%0b rdy=%0b sum=%0d want 1/0/27", out_valid, in_ready, out_sum);
      end
    end
    ena = 1'b1; wt_load = 1'b0; thr_load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    feed_words(32'h0000_0000, 4, ok);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 6'd27 || out_bit !== 1'b1) begin
      n_fail++; $display("FAIL ena_gating: valid=%0b sum=%0d bit=%0b want 1/27/1", out_valid, out_sum, out_bit);
    end
  endtask

  task automatic test_random();
    int grp[$];
    bit m_valid = 1'b0;
    int m_sum = 0;
    bit m_bit = 1'b0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      n_checks++;
      if (in_ready !== (ena && !m_valid) || out_valid !== m_valid ||
          int'(out_sum) != m_sum || out_bit !== m_bit) begin
        n_fail++;
        $display("FAIL random: cycle %0d rdy=%0b valid=%0b sum=%0d bit=%0b want %0b/%0b/%0d/%0b",
                 c, in_ready, out_valid, out_sum, out_bit, ena && !m_valid, m_valid, m_sum, m_bit);
      end
      ena       = ($urandom_range(0, 7) != 0);
      in_valid  = $urandom_range(0, 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) == 0);
      wt_load   = ($urandom_range(0, 5) == 0);
      wt_data   = 8'($urandom);
      thr_load  = ($urandom_range(0, 9) == 0);
      thr_data  = ACC_W'($urandom_range(0, 32));
      if (ena) begin
        if (!m_valid && in_valid) begin
          grp.push_back($countones(~(in_data ^ m_w[grp.size()])));
          if (grp.size() == WORDS) begin
            m_sum = 0;
            foreach (grp[k]) m_sum += grp[k];
            m_bit = (m_sum >= m_thr);
            m_valid = 1'b1;
            grp.delete();
          end
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
        if (wt_load) begin
          m_w[m_ptr] = wt_data;
          m_ptr = (m_ptr + 1) % WORDS;
        end
        if (thr_load) m_thr = int'(thr_data);
      end
      @(negedge clk);
    end
    ena = 1'b1; in_valid = 1'b0; wt_load = 1'b0; thr_load = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_default_weights();
    test_reset();
    test_loaded_weights();
    test_backpressure();
    test_mid_group_reset();
    test_wrap_and_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
